writeback_queue: RTL and testbench
==================================

# writeback_queue

Writeback stage placed directly upstream of the register file's single write port. Accepts completed results from two producers in the same cycle: the memory path and the ALU path. Buffers them in a small in-order queue and drains one write per cycle into the register file. Also exposes two forwarding lookup ports, so decode can read values that are still queued and not yet written.

## Interface
Parameters:
- N, 5, register index width
- WIDTH, 32, data width
- DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous and active-high
- mem_valid  input  1  memory-path result present this cycle
- mem_rd  input  N  memory-path destination register
- mem_data  input  WIDTH  memory-path result
- alu_valid  input  1  ALU-path result present this cycle
- alu_rd  input  N  ALU-path destination register
- alu_data  input  WIDTH  ALU-path result
- stall  output  1  producers must hold off; registered
- rf_wenable  output  1  register-file write enable
- rf_reg  output  N  register-file write index
- rf_din  output  WIDTH  register-file write data
- fwd_a, fwd_b  input  N  forwarding lookup indices
- fwd_a_hit, fwd_b_hit  output  1  lookup matched a queued entry
- fwd_a_data, fwd_b_data  output  WIDTH  data of the youngest matching entry

## Operation
- Accept: an input is accepted when its valid=1 and stall=0. Inputs presented while stall=1 are ignored; no error is raised.
- Drop r0: an accepted input with rd=0 is discarded and never enqueued (r0 stays zero).
- Push order: same-cycle pushes enqueue mem first, then alu; mem is the older instruction.
- Pushes per cycle: 0, 1 or 2.
- Drain: when the queue is non-empty, the head drives rf_wenable=1, rf_reg=head.rd, rf_din=head.data. The head pops at the same edge.
- Empty queue: rf_wenable=0, rf_reg=0, rf_din=0.
- Count update: count_next = count + pushes − pop. A push and a pop may occur in the same cycle.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Stall: stall_next = (count_next > DEPTH−2). Two free slots are always guaranteed to an unstalled cycle, so overflow is impossible.
- Forwarding (combinational):
  - fwd_x_hit=1 iff fwd_x≠0 and some valid entry, including the head, has rd==fwd_x.
  - fwd_x_data comes from the youngest such entry.
  - On a miss, fwd_x_hit=0 and fwd_x_data=0.
  - Entries being pushed this cycle are not visible until the next cycle.
- Reset: rst=1 at a rising edge clears pointers and count and sets stall=0. If asserted mid-operation, queued writes are discarded, not written. While rst=1, rf_wenable=0 and fwd hits=0.

## Timing
- Latency: an input accepted at edge E into an empty queue appears on the rf_* ports in the cycle after E. The register file commits it at edge E+1.
- Throughput: one register-file write per cycle.
- Same-rd ordering: two writes to the same rd reach the register file in push order. Last write wins.
- Full queue: stall rises in the cycle after count_next exceeds DEPTH−2. It falls in the cycle after count_next ≤ DEPTH−2.
- Reset values:
  - stall=0, rf_wenable=0, rf_reg=0, rf_din=0
  - fwd_a_hit=0, fwd_b_hit=0, fwd_a_data=0, fwd_b_data=0

## Structure
- Shared package wb_pkg:
  - typedef wb_entry_t {logic [N-1:0] rd; logic [WIDTH-1:0] data;}
  - localparam REG_ZERO = 0
- Sub-module wb_queue: circular storage, dual push, single pop, count, and youngest-first associative search for two lookup ports.
- writeback_queue: instantiates wb_queue and adds the accept/drop logic, the stall register and the rf_* drive.

## Test plan
- Single write: mem_valid=1, mem_rd=15, mem_data=2047 for one cycle → next cycle rf_wenable=1, rf_reg=15, rf_din=2047. Queue then empties and rf_wenable=0.
- Dual push ordering: mem(rd=3, data=0x11) and alu(rd=3, data=0x22) in the same cycle → rf writes 0x11, then 0x22 on consecutive cycles. During the first write cycle, fwd_a=3 returns hit=1, data=0x22.
- r0 drop: alu_valid=1, alu_rd=0, alu_data=5 → rf_wenable never asserts, and fwd_a=0 gives hit=0.
- Fill and stall (DEPTH=4): two dual pushes back to back → stall=1 after the second. Inputs presented while stalled are not written. Stall clears once count ≤ 2, and no entry is lost or duplicated.
- Wrap-around: 10 single pushes with rd=1..10 and data=rd*100 → rf sees exactly that sequence in order.
- Reset mid-operation: 3 entries queued, rst=1 for one cycle → rf_wenable=0, stall=0 and fwd hits=0 afterwards. The dropped entries are never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Default entry layout matches the core's 5-bit index / 32-bit datapath.
package wb_pkg;

  localparam int N_DEF     = 5;
  localparam int WIDTH_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef struct packed {
    logic [N_DEF-1:0]     rd;
    logic [WIDTH_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular in-order result buffer: dual push, single pop,
// plus two youngest-first associative lookup ports.
import wb_pkg::*;

module wb_queue #(
  parameter int N     = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push0,
  input  logic [N-1:0]     i_rd0,
  input  logic [WIDTH-1:0] i_data0,
  input  logic             i_push1,
  input  logic [N-1:0]     i_rd1,
  input  logic [WIDTH-1:0] i_data1,
  input  logic             i_pop,
  output logic [AW:0]      o_count_next,
  output logic             o_head_valid,
  output logic [N-1:0]     o_head_rd,
  output logic [WIDTH-1:0] o_head_data,
  input  logic [N-1:0]     i_fwd_a,
  input  logic [N-1:0]     i_fwd_b,
  output logic             o_hit_a,
  output logic [WIDTH-1:0] o_data_a,
  output logic             o_hit_b,
  output logic [WIDTH-1:0] o_data_b
);

  typedef struct packed {
    logic [N-1:0]     rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic [AW-1:0] w_wp1;
  logic [AW-1:0] w_nwr;

  assign w_pop = i_pop & (r_count != '0);
  assign w_wp1 = r_wptr + AW'(1);
  assign w_nwr = AW'({1'b0, i_push0}) + AW'({1'b0, i_push1});

  assign o_count_next = r_count
                      + (AW+1)'(i_push0)
                      + (AW+1)'(i_push1)
                      - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + AW'(w_pop);
      r_wptr  <= r_wptr + w_nwr;
      r_count <= o_count_next;
    end
  end

  // Slot 1 is only used when slot 0 is also pushed.
  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wptr] <= '{rd: i_rd0, data: i_data0};
    if (i_push1) r_mem[w_wp1]  <= '{rd: i_rd1, data: i_data1};
  end

  assign o_head_valid = (r_count != '0);
  assign o_head_rd    = r_mem[r_rptr].rd;
  assign o_head_data  = r_mem[r_rptr].data;

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    logic          live;
    o_hit_a  = 1'b0;
    o_data_a = '0;
    o_hit_b  = 1'b0;
    o_data_b = '0;
    idx      = '0;
    live     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = r_rptr + AW'(i);
      live = ((AW+1)'(i) < r_count);
      if (live && i_fwd_a != N'(REG_ZERO)
          && r_mem[idx].rd == i_fwd_a) begin
        o_hit_a  = 1'b1;
        o_data_a = r_mem[idx].data;
      end
      if (live && i_fwd_b != N'(REG_ZERO)
          && r_mem[idx].rd == i_fwd_b) begin
        o_hit_b  = 1'b1;
        o_data_b = r_mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage ahead of the single register-file write port:
// merges mem/ALU results, drops r0, drains one write per cycle.
import wb_pkg::*;

module writeback_queue #(
  parameter int N     = 5,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [N-1:0]     mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             alu_valid,
  input  logic [N-1:0]     alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             stall,
  output logic             rf_wenable,
  output logic [N-1:0]     rf_reg,
  output logic [WIDTH-1:0] rf_din,
  input  logic [N-1:0]     fwd_a,
  input  logic [N-1:0]     fwd_b,
  output logic             fwd_a_hit,
  output logic             fwd_b_hit,
  output logic [WIDTH-1:0] fwd_a_data,
  output logic [WIDTH-1:0] fwd_b_data
);

  logic             r_stall;
  logic             w_acc_mem;
  logic             w_acc_alu;
  logic             w_push0;
  logic             w_push1;
  logic [N-1:0]     w_rd0;
  logic [WIDTH-1:0] w_data0;
  logic [AW:0]      w_count_next;
  logic             w_head_valid;
  logic [N-1:0]     w_head_rd;
  logic [WIDTH-1:0] w_head_data;
  logic             w_hit_a;
  logic             w_hit_b;
  logic [WIDTH-1:0] w_data_a;
  logic [WIDTH-1:0] w_data_b;
  logic             w_drain;

  assign w_acc_mem = mem_valid & ~r_stall & ~rst
                   & (mem_rd != N'(REG_ZERO));
  assign w_acc_alu = alu_valid & ~r_stall & ~rst
                   & (alu_rd != N'(REG_ZERO));

  // Compact survivors: mem (older) takes slot 0 when present.
  assign w_push0 = w_acc_mem | w_acc_alu;
  assign w_push1 = w_acc_mem & w_acc_alu;
  assign w_rd0   = w_acc_mem ? mem_rd   : alu_rd;
  assign w_data0 = w_acc_mem ? mem_data : alu_data;

  wb_queue #(
    .N     (N),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push0      (w_push0),
    .i_rd0        (w_rd0),
    .i_data0      (w_data0),
    .i_push1      (w_push1),
    .i_rd1        (alu_rd),
    .i_data1      (alu_data),
    .i_pop        (~rst),
    .o_count_next (w_count_next),
    .o_head_valid (w_head_valid),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .i_fwd_a      (fwd_a),
    .i_fwd_b      (fwd_b),
    .o_hit_a      (w_hit_a),
    .o_data_a     (w_data_a),
    .o_hit_b      (w_hit_b),
    .o_data_b     (w_data_b)
  );

  // Stall keeps two slots free for any unstalled cycle.
  always_ff @(posedge clk) begin
    if (rst) r_stall <= 1'b0;
    else     r_stall <= (w_count_next > (AW+1)'(DEPTH-2));
  end

  assign stall = r_stall;

  assign w_drain    = w_head_valid & ~rst;
  assign rf_wenable = w_drain;
  assign rf_reg     = w_drain ? w_head_rd   : '0;
  assign rf_din     = w_drain ? w_head_data : '0;

  assign fwd_a_hit  = w_hit_a & ~rst;
  assign fwd_b_hit  = w_hit_b & ~rst;
  assign fwd_a_data = rst ? '0 : w_data_a;
  assign fwd_b_data = rst ? '0 : w_data_b;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_writeback_queue;

  localparam int N = 5;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_valid = 1'b0;
  logic [N-1:0] mem_rd = '0;
  logic [W-1:0] mem_data = '0;
  logic         alu_valid = 1'b0;
  logic [N-1:0] alu_rd = '0;
  logic [W-1:0] alu_data = '0;
  logic [N-1:0] fwd_a = '0;
  logic [N-1:0] fwd_b = '0;
  logic         stall;
  logic         rf_wenable;
  logic [N-1:0] rf_reg;
  logic [W-1:0] rf_din;
  logic         fwd_a_hit;
  logic         fwd_b_hit;
  logic [W-1:0] fwd_a_data;
  logic [W-1:0] fwd_b_data;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.N(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .stall      (stall),
    .rf_wenable (rf_wenable),
    .rf_reg     (rf_reg),
    .rf_din     (rf_din),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_data (fwd_b_data)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: plain FIFO of pending writes, oldest at index 0.
  logic [N-1:0] qrd[$];
  logic [W-1:0] qdat[$];
  logic         m_stall = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      qrd.delete();
      qdat.delete();
      m_stall = 1'b0;
    end else begin
      if (qrd.size() > 0) begin
        void'(qrd.pop_front());
        void'(qdat.pop_front());
      end
      if (!m_stall && mem_valid && mem_rd != 0) begin
        qrd.push_back(mem_rd);
        qdat.push_back(mem_data);
      end
      if (!m_stall && alu_valid && alu_rd != 0) begin
        qrd.push_back(alu_rd);
        qdat.push_back(alu_data);
      end
      m_stall = (qrd.size() > D - 2);
    end
  end

  function automatic void lookup(input logic [N-1:0] k,
                                 output logic h,
                                 output logic [W-1:0] d);
    h = 1'b0;
    d = '0;
    if (rst || k == 0) return;
    for (int i = qrd.size() - 1; i >= 0; i--) begin
      if (qrd[i] == k) begin
        h = 1'b1;
        d = qdat[i];
        return;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic         ew;
    logic         eh;
    logic [W-1:0] ed;
    ew = !rst && qrd.size() > 0;
    cmp("m_stall", 64'(stall), 64'(m_stall));
    cmp("m_wen", 64'(rf_wenable), 64'(ew));
    if (!rst) begin
      cmp("m_reg", 64'(rf_reg), ew ? 64'(qrd[0]) : 64'd0);
      cmp("m_din", 64'(rf_din), ew ? 64'(qdat[0]) : 64'd0);
    end
    lookup(fwd_a, eh, ed);
    cmp("m_hit_a", 64'(fwd_a_hit), 64'(eh));
    cmp("m_data_a", 64'(fwd_a_data), 64'(ed));
    lookup(fwd_b, eh, ed);
    cmp("m_hit_b", 64'(fwd_b_hit), 64'(eh));
    cmp("m_data_b", 64'(fwd_b_data), 64'(ed));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [N-1:0] mr,
                       input logic [W-1:0] md, input logic av,
                       input logic [N-1:0] ar, input logic [W-1:0] ad);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    tick();
    tick();
    cmp("rst_stall", 64'(stall), 64'd0);
    cmp("rst_wen", 64'(rf_wenable), 64'd0);
    cmp("rst_reg", 64'(rf_reg), 64'd0);
    cmp("rst_din", 64'(rf_din), 64'd0);
    cmp("rst_hit_a", 64'(fwd_a_hit), 64'd0);
    cmp("rst_hit_b", 64'(fwd_b_hit), 64'd0);
    cmp("rst_dat_a", 64'(fwd_a_data), 64'd0);
    cmp("rst_dat_b", 64'(fwd_b_data), 64'd0);
    rst = 1'b0;
    tick();

    // Single write
    drive(1'b1, 5'd15, 32'd2047, 1'b0, '0, '0);
    tick();
    idle();
    cmp("single_wen", 64'(rf_wenable), 64'd1);
    cmp("single_reg", 64'(rf_reg), 64'd15);
    cmp("single_din", 64'(rf_din), 64'd2047);
    tick();
    cmp("single_empty", 64'(rf_wenable), 64'd0);

    // Dual push, same rd
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    fwd_a = 5'd3;
    tick();
    idle();
    cmp("dual_din0", 64'(rf_din), 64'h11);
    cmp("dual_reg0", 64'(rf_reg), 64'd3);
    cmp("dual_hit0", 64'(fwd_a_hit), 64'd1);
    cmp("dual_fwd0", 64'(fwd_a_data), 64'h22);
    tick();
    cmp("dual_din1", 64'(rf_din), 64'h22);
    cmp("dual_fwd1", 64'(fwd_a_data), 64'h22);
    tick();
    cmp("dual_done", 64'(rf_wenable), 64'd0);
    cmp("dual_miss", 64'(fwd_a_hit), 64'd0);

    // r0 drop
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'd5);
    fwd_a = 5'd0;
    tick();
    idle();
    cmp("r0_wen", 64'(rf_wenable), 64'd0);
    cmp("r0_hit", 64'(fwd_a_hit), 64'd0);
    tick();
    cmp("r0_wen2", 64'(rf_wenable), 64'd0);

    // Fill and stall
    fwd_b = 5'd5;
    drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd5, 32'h50);
    tick();
    cmp("fill_stall0", 64'(stall), 64'd0);
    cmp("fill_reg0", 64'(rf_reg), 64'd4);
    drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
    tick();
    cmp("fill_stall1", 64'(stall), 64'd1);
    cmp("fill_reg1", 64'(rf_reg), 64'd5);
    cmp("fill_hit_b", 64'(fwd_b_hit), 64'd1);
    cmp("fill_fwd_b", 64'(fwd_b_data), 64'h50);
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98);
    tick();
    idle();
    cmp("fill_stall2", 64'(stall), 64'd0);
    cmp("fill_reg2", 64'(rf_reg), 64'd6);
    tick();
    cmp("fill_reg3", 64'(rf_reg), 64'd7);
    cmp("fill_din3", 64'(rf_din), 64'h70);
    tick();
    cmp("fill_empty", 64'(rf_wenable), 64'd0);
    fwd_b = 5'd0;

    // Wrap-around: pointers cycle past DEPTH
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, N'(i), W'(i * 100), 1'b0, '0, '0);
      tick();
      cmp("wrap_reg", 64'(rf_reg), 64'(i));
      cmp("wrap_din", 64'(rf_din), 64'(i * 100));
    end
    idle();
    tick();
    cmp("wrap_empty", 64'(rf_wenable), 64'd0);

    // Reset with three entries pending
    drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
    tick();
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
    fwd_b = 5'd12;
    tick();
    idle();
    cmp("pre_rst_hit", 64'(fwd_b_hit), 64'd1);
    cmp("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    cmp("in_rst_wen", 64'(rf_wenable), 64'd0);
    cmp("in_rst_hit", 64'(fwd_b_hit), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    cmp("post_rst_wen", 64'(rf_wenable), 64'd0);
    cmp("post_rst_stall", 64'(stall), 64'd0);
    cmp("post_rst_hit", 64'(fwd_b_hit), 64'd0);
    tick();
    cmp("post_rst_wen2", 64'(rf_wenable), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
